pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// synchronous flush with NOP bubbles, and saturating bubble/flush profiling counters.
module pipe_stage_skid #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              accept;
    logic              pop;
    logic [1:0]        occ_nxt;

    assign accept = in_valid & in_ready & ~flush;
    assign pop    = out_valid & out_ready;

    always_comb begin
        occ_nxt = occupancy;
        if (flush) begin
            occ_nxt = OCC_EMPTY;
        end else begin
            case (occupancy)
                OCC_EMPTY: if (accept) occ_nxt = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !pop)      occ_nxt = OCC_TWO;
                    else if (!accept && pop) occ_nxt = OCC_EMPTY;
                end
                OCC_TWO:   if (pop) occ_nxt = OCC_ONE;
                default:   occ_nxt = OCC_EMPTY;
            endcase
        end
    end

    // out_valid/in_ready are registered copies of the next occupancy, keeping
    // every output a flop with no path from the handshake inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_ctrl  <= '0;
            out_data  <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            occupancy <= occ_nxt;
            out_valid <= (occ_nxt != OCC_EMPTY);
            in_ready  <= (occ_nxt != OCC_TWO);
            if (flush) begin
                out_ctrl  <= '0;
                out_data  <= '0;
                skid_ctrl <= '0;
                skid_data <= '0;
            end else begin
                case (occupancy)
                    OCC_EMPTY: begin
                        if (accept) begin
                            out_ctrl <= in_ctrl;
                            out_data <= in_data;
                        end
                    end
                    OCC_ONE: begin
                        if (accept && pop) begin
                            out_ctrl <= in_ctrl;
                            out_data <= in_data;
                        end else if (accept) begin
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                        end else if (pop) begin
                            // Drain to empty: control becomes a NOP, data is left as-is.
                            out_ctrl <= '0;
                        end
                    end
                    OCC_TWO: begin
                        if (pop) begin
                            out_ctrl <= skid_ctrl;
                            out_data <= skid_data;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (out_ready && !out_valid && (bubble_cnt != {CNT_W{1'b1}}))
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (flush && ((occupancy != OCC_EMPTY) || in_valid) && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: queue-based reference model compared every
// cycle, plus literal expectations at the points the test plan names.
module tb_pipe_stage_skid;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] bubble_cnt;
    logic [NW-1:0] flush_cnt;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats plus saturating counters.
    typedef struct packed { logic [CW-1:0] ctrl; logic [DW-1:0] data; } beat_t;
    beat_t   mq[$];
    logic [DW-1:0] m_last = '0;
    int      m_bub = 0;
    int      m_fl  = 0;
    localparam int CMAX = (1 << NW) - 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_last = '0;
            m_bub  = 0;
            m_fl   = 0;
        end else begin
            bit acc, pp;
            acc = in_valid && (mq.size() < 2) && !flush;
            pp  = (mq.size() > 0) && out_ready;
            if (out_ready && mq.size() == 0 && m_bub < CMAX) m_bub++;
            if (flush) begin
                if ((mq.size() != 0 || in_valid) && m_fl < CMAX) m_fl++;
                mq.delete();
                m_last = '0;
            end else begin
                if (pp) begin
                    m_last = mq[0].data;
                    void'(mq.pop_front());
                end
                if (acc) mq.push_back('{ctrl: in_ctrl, data: in_data});
            end
        end
    end

    logic [DW-1:0] popped[$];

    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
            check("in_ready",  32'(in_ready),  32'(mq.size() < 2));
            check("occupancy", 32'(occupancy), 32'(mq.size()));
            check("out_ctrl",  32'(out_ctrl),  mq.size() > 0 ? 32'(mq[0].ctrl) : 32'd0);
            check("out_data",  32'(out_data),  mq.size() > 0 ? 32'(mq[0].data) : 32'(m_last));
            check("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
            check("flush_cnt",  32'(flush_cnt),  32'(m_fl));
            if (reset && out_valid && out_ready) popped.push_back(out_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic check_popped(input string name, input logic [DW-1:0] exp[$]);
        check({name, "_count"}, 32'(popped.size()), 32'(exp.size()));
        foreach (exp[i])
            if (i < popped.size()) check(name, 32'(popped[i]), 32'(exp[i]));
        popped.delete();
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];

        // Reset with a beat presented upstream.
        drive(1'b1, 8'h55, 16'hAAAA);
        #1 reset = 1'b0;
        started = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ctrl",  32'(out_ctrl),  32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_bubble",    32'(bubble_cnt), 32'd0);
        repeat (2) cyc();

        // Idle after reset: five bubbles.
        reset = 1'b1;
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        repeat (5) cyc();
        check("idle_bubble5", 32'(bubble_cnt), 32'd5);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, CW'(i + 1), DW'(i));
            cyc();
            if (i == 0) check("stream_latency", 32'(out_valid), 32'd1);
            check("stream_occ_le1", 32'(occupancy <= 2'd1), 32'd1);
        end
        drive(1'b0, '0, '0);
        repeat (2) cyc();
        exp_q = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        check_popped("stream_order", exp_q);

        // Back-pressure: A, B fill the stage, C waits upstream.
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 16'h00A1); cyc();
        drive(1'b1, 8'h02, 16'h00B2); cyc();
        drive(1'b1, 8'h03, 16'h00C3); cyc();
        check("bp_occ",      32'(occupancy), 32'd2);
        check("bp_in_ready", 32'(in_ready),  32'd0);
        check("bp_head",     32'(out_data),  32'h00A1);
        check("bp_ctrl",     32'(out_ctrl),  32'h01);
        out_ready = 1'b1;
        repeat (2) cyc();
        drive(1'b0, '0, '0);
        repeat (2) cyc();
        exp_q = '{16'h00A1, 16'h00B2, 16'h00C3};
        check_popped("bp_order", exp_q);

        // Flush at full occupancy with beat D on the input.
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 16'h0011); cyc();
        drive(1'b1, 8'h22, 16'h0022); cyc();
        check("pre_flush_occ", 32'(occupancy), 32'd2);
        drive(1'b1, 8'hDD, 16'h00DD);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_ctrl",  32'(out_ctrl),  32'd0);
        check("fl_out_data",  32'(out_data),  32'd0);
        check("fl_occ",       32'(occupancy), 32'd0);
        check("fl_in_ready",  32'(in_ready),  32'd1);
        check("fl_cnt1",      32'(flush_cnt), 32'd1);
        out_ready = 1'b1;
        repeat (3) cyc();
        exp_q = {};
        check_popped("fl_no_d", exp_q);

        // Flush while empty: idle does not count, a dropped beat does.
        flush = 1'b1;
        cyc();
        check("fl_empty_idle", 32'(flush_cnt), 32'd1);
        drive(1'b1, 8'hEE, 16'h00EE);
        cyc();
        check("fl_empty_beat", 32'(flush_cnt), 32'd2);
        repeat (2) cyc();
        check("fl_multi_cnt", 32'(flush_cnt), 32'd4);
        check("fl_multi_occ", 32'(occupancy), 32'd0);
        flush = 1'b0;
        drive(1'b0, '0, '0);
        cyc();

        // Flush coinciding with a pop still delivers the head beat.
        out_ready = 1'b0;
        drive(1'b1, 8'h77, 16'h0077); cyc();
        drive(1'b0, '0, '0);
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        exp_q = '{16'h0077};
        check_popped("fl_pop", exp_q);
        check("fl_pop_cnt", 32'(flush_cnt), 32'd5);

        // Bubble counter saturation.
        repeat (20) cyc();
        check("bubble_sat", 32'(bubble_cnt), 32'd15);

        // Reset in the middle of a full stage.
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 16'h0031); cyc();
        drive(1'b1, 8'h32, 16'h0032); cyc();
        check("pre_rst_occ", 32'(occupancy), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("mrst_occ",      32'(occupancy),  32'd0);
        check("mrst_valid",    32'(out_valid),  32'd0);
        check("mrst_in_ready", 32'(in_ready),   32'd1);
        check("mrst_data",     32'(out_data),   32'd0);
        check("mrst_bubble",   32'(bubble_cnt), 32'd0);
        check("mrst_flush",    32'(flush_cnt),  32'd0);
        cyc();
        reset = 1'b1;
        drive(1'b0, '0, '0);
        popped.delete();
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
